// File: rtl/rx_lane_pkg.sv
// Shared definitions for the RX lane bring-up path: state encodings,
// default timeouts and the lane-status bundle used by the alignment logic.
package rx_lane_pkg;

  localparam logic [2:0] ST_IDLE       = 3'b000;
  localparam logic [2:0] ST_WAIT_BLOCK = 3'b001;
  localparam logic [2:0] ST_CLEAR      = 3'b010;
  localparam logic [2:0] ST_HUNT       = 3'b011;
  localparam logic [2:0] ST_UP         = 3'b100;
  localparam logic [2:0] ST_HOLDOFF    = 3'b101;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    WAIT_BLOCK = ST_WAIT_BLOCK,
    CLEAR      = ST_CLEAR,
    HUNT       = ST_HUNT,
    UP         = ST_UP,
    HOLDOFF    = ST_HOLDOFF
  } lane_state_e;

  localparam int DEF_META_FRAME_LEN      = 16;
  localparam int DEF_HUNT_TIMEOUT_FRAMES = 8;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_HOLDOFF_CYCLES      = 16;
  localparam int DEF_LOSS_CNT_WIDTH      = 8;
  localparam int CLEAR_CYCLES            = 2;

  typedef struct packed {
    logic descr_reset;
    logic descr_passthrough;
    logic resync_req;
    logic lane_up;
  } lane_status_t;

  localparam lane_status_t LANE_STATUS_RST = '{
    descr_reset: 1'b1, descr_passthrough: 1'b0, resync_req: 1'b0, lane_up: 1'b0
  };

endpackage

// File: rtl/rx_lane_timer.sv
// Loadable, saturating, enable-gated up-counter with a terminal-count flag.
// Load wins over enable; the count holds once it reaches tc_val.
module rx_lane_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == tc_val);

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_lane_lock_ctrl.sv
// Per-lane RX bring-up: sequences descrambler reset/passthrough, retries
// failed hunts and escalates to a block-sync resync request.
//
// state      | meaning
// IDLE       | lane disabled or bypassed, descrambler in reset
// WAIT_BLOCK | waiting for block sync
// CLEAR      | descrambler reset for two clocks before a hunt
// HUNT       | descrambler searching for lock, word timer running
// UP         | lane locked and descrambling
// HOLDOFF    | descrambler held in reset after lock loss or resync
module rx_lane_lock_ctrl
  import rx_lane_pkg::*;
#(
  parameter int META_FRAME_LEN      = DEF_META_FRAME_LEN,
  parameter int HUNT_TIMEOUT_FRAMES = DEF_HUNT_TIMEOUT_FRAMES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int HOLDOFF_CYCLES      = DEF_HOLDOFF_CYCLES,
  parameter int LOSS_CNT_WIDTH      = DEF_LOSS_CNT_WIDTH
) (
  input  logic                      USER_CLK,
  input  logic                      SYSTEM_RESET_N,
  input  logic                      ENABLE,
  input  logic                      BYPASS,
  input  logic                      BLOCK_LOCK,
  input  logic                      DATA_IN_VALID,
  input  logic                      DESCR_NOT_LOCKED,
  output logic                      DESCR_RESET,
  output logic                      DESCR_PASSTHROUGH,
  output logic                      RESYNC_REQ,
  output logic                      LANE_UP,
  output logic [LOSS_CNT_WIDTH-1:0] LOCK_LOSS_CNT,
  output logic [2:0]                STATE_OUT
);

  localparam int HUNT_WORDS = HUNT_TIMEOUT_FRAMES * META_FRAME_LEN;
  localparam int WORD_W     = $clog2(HUNT_WORDS);
  localparam int CYC_W      = $clog2(HOLDOFF_CYCLES);
  localparam int RETRY_W    = $clog2(MAX_RETRIES + 1);

  localparam logic [WORD_W-1:0]  WORD_TC   = WORD_W'(HUNT_WORDS - 1);
  localparam logic [CYC_W-1:0]   HOLD_TC   = CYC_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CYC_W-1:0]   CLEAR_TC  = CYC_W'(CLEAR_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  lane_state_e               state_q, state_d;
  logic [RETRY_W-1:0]        retry_q, retry_d, retry_inc;
  logic [LOSS_CNT_WIDTH-1:0] loss_q, loss_d;
  lane_status_t              status_q, status_d;
  logic                      resync_d;
  logic                      word_load, word_tc, timeout;
  logic                      cyc_load, cyc_tc;
  logic [CYC_W-1:0]          cyc_tc_val;

  // Word timer is held at zero outside HUNT, so every hunt starts fresh.
  assign word_load = (state_q != HUNT);
  assign timeout   = word_tc && DATA_IN_VALID;

  // One cycle counter serves both CLEAR and HOLDOFF; they are never adjacent.
  assign cyc_load   = !((state_q == CLEAR) || (state_q == HOLDOFF));
  assign cyc_tc_val = (state_q == CLEAR) ? CLEAR_TC : HOLD_TC;

  rx_lane_timer #(.WIDTH(WORD_W)) u_word_timer (
    .clk    (USER_CLK),
    .rst_n  (SYSTEM_RESET_N),
    .load   (word_load),
    .en     (DATA_IN_VALID),
    .tc_val (WORD_TC),
    .tc     (word_tc)
  );

  rx_lane_timer #(.WIDTH(CYC_W)) u_cycle_counter (
    .clk    (USER_CLK),
    .rst_n  (SYSTEM_RESET_N),
    .load   (cyc_load),
    .en     (1'b1),
    .tc_val (cyc_tc_val),
    .tc     (cyc_tc)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    resync_d = 1'b0;
    if (!ENABLE || BYPASS) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_BLOCK;
          retry_d = '0;
        end
        WAIT_BLOCK: if (BLOCK_LOCK) state_d = CLEAR;
        CLEAR:      if (cyc_tc) state_d = HUNT;
        HUNT: begin
          if (!DESCR_NOT_LOCKED) begin
            state_d = UP;
            retry_d = '0;
          end else if (!BLOCK_LOCK) begin
            state_d = WAIT_BLOCK;
          end else if (timeout) begin
            if (retry_inc == RETRY_MAX) begin
              state_d  = HOLDOFF;
              retry_d  = '0;
              resync_d = 1'b1;
            end else begin
              state_d = CLEAR;
              retry_d = retry_inc;
            end
          end
        end
        UP:      if (DESCR_NOT_LOCKED || !BLOCK_LOCK) state_d = HOLDOFF;
        HOLDOFF: if (cyc_tc) state_d = WAIT_BLOCK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    loss_d = loss_q;
    if ((state_q == UP) && (state_d == HOLDOFF) && (loss_q != '1))
      loss_d = loss_q + LOSS_CNT_WIDTH'(1);
  end

  // Outputs decode the next state so they line up with the state register.
  always_comb begin
    status_d.descr_reset       = !((state_d == HUNT) || (state_d == UP));
    status_d.descr_passthrough = (state_d == IDLE) && BYPASS;
    status_d.resync_req        = resync_d;
    status_d.lane_up           = (state_d == UP);
  end

  always_ff @(posedge USER_CLK) begin
    if (!SYSTEM_RESET_N) begin
      state_q  <= IDLE;
      retry_q  <= '0;
      loss_q   <= '0;
      status_q <= LANE_STATUS_RST;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      status_q <= status_d;
    end
  end

  assign DESCR_RESET       = status_q.descr_reset;
  assign DESCR_PASSTHROUGH = status_q.descr_passthrough;
  assign RESYNC_REQ        = status_q.resync_req;
  assign LANE_UP           = status_q.lane_up;
  assign LOCK_LOSS_CNT     = loss_q;
  assign STATE_OUT         = state_q;

endmodule

// File: tb/tb_rx_lane_lock_ctrl.sv
// Directed bench for rx_lane_lock_ctrl: expected output words are queued as
// each step is driven and checked one clock later.
module tb_rx_lane_lock_ctrl;
  import rx_lane_pkg::*;

  logic       clk;
  logic       rst_n, en, byp, blk, vld, dnl;
  logic       descr_reset, descr_passthrough, resync_req, lane_up;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_out;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] exp_lc;

  rx_lane_lock_ctrl dut (
    .USER_CLK          (clk),
    .SYSTEM_RESET_N    (rst_n),
    .ENABLE            (en),
    .BYPASS            (byp),
    .BLOCK_LOCK        (blk),
    .DATA_IN_VALID     (vld),
    .DESCR_NOT_LOCKED  (dnl),
    .DESCR_RESET       (descr_reset),
    .DESCR_PASSTHROUGH (descr_passthrough),
    .RESYNC_REQ        (resync_req),
    .LANE_UP           (lane_up),
    .LOCK_LOSS_CNT     (lock_loss_cnt),
    .STATE_OUT         (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Push the expected output word for the next clock, clock once, then compare.
  task automatic tick(input string tag, input logic [2:0] st,
                      input logic rs = 1'b0, input logic pt = 1'b0);
    exp_t        e;
    logic [14:0] obs;
    e.tag = tag;
    e.val = {st, !((st == ST_HUNT) || (st == ST_UP)), pt, rs, (st == ST_UP), exp_lc};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {state_out, descr_reset, descr_passthrough, resync_req, lane_up, lock_loss_cnt};
    compared++;
    assert (obs === e.val)
      else begin
        mismatched++;
        $error("FAIL %s: observed st=%b rst=%b pt=%b rs=%b up=%b lc=%0d, expected st=%b rst=%b pt=%b rs=%b up=%b lc=%0d",
               e.tag, obs[14:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
               e.val[14:12], e.val[11], e.val[10], e.val[9], e.val[8], e.val[7:0]);
      end
  endtask

  // Two CLEAR clocks, then n clocks in HUNT; alt makes DATA_IN_VALID toggle.
  task automatic hunt(input string tag, input int n, input bit alt);
    tick({tag, "_clear0"}, ST_CLEAR);
    tick({tag, "_clear1"}, ST_CLEAR);
    tick({tag, "_hunt_entry"}, ST_HUNT);
    for (int k = 1; k < n; k++) begin
      vld = alt ? k[0] : 1'b1;
      tick({tag, "_hunt"}, ST_HUNT);
    end
  endtask

  // Sixteen HOLDOFF clocks followed by one WAIT_BLOCK clock.
  task automatic holdoff(input string tag, input logic rs_first);
    tick({tag, "_holdoff_entry"}, ST_HOLDOFF, rs_first);
    blk = 1'b1;
    for (int k = 1; k < 16; k++)
      tick({tag, "_holdoff"}, ST_HOLDOFF);
    tick({tag, "_wait_block"}, ST_WAIT_BLOCK);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; byp = 1'b0; blk = 1'b0; vld = 1'b0; dnl = 1'b1;
    exp_lc = 8'd0;
    tick("reset", ST_IDLE);
    tick("reset_hold", ST_IDLE);

    // Bring-up: lock on the 80th valid word.
    rst_n = 1'b1; en = 1'b1;
    tick("enable", ST_WAIT_BLOCK);
    tick("no_block_lock", ST_WAIT_BLOCK);
    blk = 1'b1; vld = 1'b1;
    hunt("bringup", 80, 1'b0);
    dnl = 1'b0;
    tick("bringup_up", ST_UP);

    // Three timeouts (first one with sparse valid words) end in a resync.
    dnl = 1'b1; exp_lc = exp_lc + 8'd1;
    holdoff("loss_a", 1'b0);
    hunt("retry1", 255, 1'b1);
    vld = 1'b1;
    hunt("retry2", 128, 1'b0);
    hunt("retry3", 128, 1'b0);
    holdoff("resync_a", 1'b1);

    // Lock and timeout together: lock wins and clears the retry count.
    hunt("lt_1", 128, 1'b0);
    hunt("lt_2", 128, 1'b0);
    dnl = 1'b0;
    tick("lock_and_timeout", ST_UP);
    dnl = 1'b1; exp_lc = exp_lc + 8'd1;
    holdoff("loss_b", 1'b0);
    hunt("lt_r1", 128, 1'b0);
    hunt("lt_r2", 128, 1'b0);
    hunt("lt_r3", 128, 1'b0);
    holdoff("resync_b", 1'b1);

    // Block lock drop with timeout: back to WAIT_BLOCK, no retry consumed.
    hunt("bd", 128, 1'b0);
    blk = 1'b0;
    tick("blk_drop_timeout", ST_WAIT_BLOCK);
    tick("blk_drop_wait", ST_WAIT_BLOCK);
    blk = 1'b1;
    hunt("bd_r1", 128, 1'b0);
    hunt("bd_r2", 128, 1'b0);
    hunt("bd_r3", 128, 1'b0);
    holdoff("resync_c", 1'b1);

    // Repeated lock loss saturates the loss counter.
    hunt("pre_up", 5, 1'b0);
    dnl = 1'b0;
    tick("pre_up_lock", ST_UP);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 1) blk = 1'b0;
      else            dnl = 1'b1;
      if (exp_lc != 8'hff) exp_lc = exp_lc + 8'd1;
      holdoff("loss_loop", 1'b0);
      dnl = 1'b0;
      hunt("relock", 1, 1'b0);
      tick("relock_up", ST_UP);
    end

    // Bypass from UP; counter survives.
    byp = 1'b1;
    tick("bypass", ST_IDLE, 1'b0, 1'b1);
    tick("bypass_hold", ST_IDLE, 1'b0, 1'b1);
    byp = 1'b0;
    tick("unbypass", ST_WAIT_BLOCK);

    // Disable mid-HUNT.
    dnl = 1'b1;
    hunt("pre_dis", 3, 1'b0);
    en = 1'b0;
    tick("disable", ST_IDLE);
    en = 1'b1;
    tick("reenable", ST_WAIT_BLOCK);

    // Reset mid-HUNT clears everything including the loss counter.
    hunt("pre_rst", 10, 1'b0);
    rst_n = 1'b0; exp_lc = 8'd0;
    tick("reset_mid_hunt", ST_IDLE);
    rst_n = 1'b1;
    tick("post_reset", ST_WAIT_BLOCK);

    compared++;
    assert (exp_q.size() == 0)
      else begin
        mismatched++;
        $error("FAIL scoreboard_drain: observed %0d pending, expected 0", exp_q.size());
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
